rom_rd_arbiter: RTL and testbench

- Shares one 16x8 LUT ROM (rom_16x8, built from ROM16X1 primitives) between NREQ requesters.
- Round-robin arbitration; a registered address is driven to the ROM, and the registered read data is returned with a per-requester valid pulse.
- Sits between the rom_16x8 instance and its clients. It contains the only sequential logic around the otherwise combinational ROM.

---
 rtl/rom_rd_arbiter_pkg.sv | 23 ++
 rtl/rom_rd_arbiter_rr_pick.sv | 32 +++
 rtl/rom_rd_arbiter.sv | 122 ++++++++++++
 tb/tb_rom_rd_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_rd_arbiter_pkg.sv
// Shared constants and FSM encoding for the ROM read arbiter.
// ROM_RD_ARB_SETTLE_EN adds a SETTLE state to the encoding for slow LUT-ROM timing.
package rom_rd_pkg;

   localparam int ROM_AW = 4;
   localparam int ROM_DW = 8;

`ifdef ROM_RD_ARB_SETTLE_EN
   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      READ,
      RESP
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE,
      READ,
      RESP
   } state_t;
`endif

endpackage

// File: rtl/rom_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request after i_last_gnt,
// wrapping modulo NREQ.
module rr_pick #(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_last_gnt,
   output logic            o_found,
   output logic [NREQ-1:0] o_gnt_oh,
   output logic [IDW-1:0]  o_gnt_idx
);

   logic [IDW-1:0] w_cand;

   always_comb begin
      o_found   = 1'b0;
      o_gnt_oh  = '0;
      o_gnt_idx = '0;
      w_cand    = '0;
      // Scan starts one past the last grantee so the previous winner is checked last.
      for (int unsigned k = 1; k <= NREQ; k++) begin
         w_cand = IDW'((32'(i_last_gnt) + k) % NREQ);
         if (!o_found && i_req[w_cand]) begin
            o_found          = 1'b1;
            o_gnt_idx        = w_cand;
            o_gnt_oh[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter sharing one 16x8 LUT ROM among NREQ requesters.
// Define ROM_RD_ARB_SETTLE_EN to hold rom_a one extra cycle before data capture.
module rom_rd_arbiter
   import rom_rd_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [ROM_AW*NREQ-1:0] addr,
   output logic [NREQ-1:0]        ack,
   output logic [NREQ-1:0]        rvalid,
   output logic [ROM_DW-1:0]      rdata,
   output logic                   busy,
   output logic [ROM_AW-1:0]      rom_a,
   input  logic [ROM_DW-1:0]      rom_o
);

   state_t              r_state;
   state_t              w_next;
   logic [IDW-1:0]      r_id;
   logic [IDW-1:0]      r_last_gnt;
   logic [ROM_AW-1:0]   r_rom_a;
   logic [ROM_DW-1:0]   r_rdata;

   logic                w_found;
   logic [NREQ-1:0]     w_gnt_oh;
   logic [IDW-1:0]      w_gnt_idx;
   logic [ROM_AW-1:0]   w_addr_sel;
   logic                w_load;
   logic                w_capture;

   rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .i_req      (req),
      .i_last_gnt (r_last_gnt),
      .o_found    (w_found),
      .o_gnt_oh   (w_gnt_oh),
      .o_gnt_idx  (w_gnt_idx)
   );

   always_comb begin
      w_addr_sel = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (w_gnt_idx == IDW'(i)) begin
            w_addr_sel = addr[i*ROM_AW +: ROM_AW];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      ack       = '0;
      rvalid    = '0;
      w_load    = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               ack    = w_gnt_oh;
               w_load = 1'b1;
`ifdef ROM_RD_ARB_SETTLE_EN
               w_next = SETTLE;
`else
               w_next = READ;
`endif
            end
         end
`ifdef ROM_RD_ARB_SETTLE_EN
         SETTLE: begin
            w_next = READ;
         end
`endif
         READ: begin
            w_capture = 1'b1;
            w_next    = RESP;
         end
         RESP: begin
            rvalid = NREQ'(1) << r_id;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // rom_a and rdata are only ever loaded, never cleared, so they hold while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rom_a    <= '0;
         r_rdata    <= '0;
         r_id       <= '0;
         r_last_gnt <= IDW'(NREQ - 1);
      end else begin
         if (w_load) begin
            r_rom_a    <= w_addr_sel;
            r_id       <= w_gnt_idx;
            r_last_gnt <= w_gnt_idx;
         end
         if (w_capture) begin
            r_rdata <= rom_o;
         end
      end
   end

   assign busy  = (r_state != IDLE);
   assign rom_a = r_rom_a;
   assign rdata = r_rdata;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Scoreboard bench for rom_rd_arbiter with a lookup-table model of rom_16x8.
// Latency and spacing follow ROM_RD_ARB_SETTLE_EN when it is defined.
module tb_rom_rd_arbiter;

   localparam int NREQ = 4;
`ifdef ROM_RD_ARB_SETTLE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif
   localparam int SP = LAT + 1;

   localparam logic [7:0] ROM_TBL [16] = '{
      8'h1B, 8'h2C, 8'h3D, 8'h4E, 8'h55, 8'h66, 8'h77, 8'h81,
      8'h8B, 8'h92, 8'hA3, 8'hB4, 8'hC5, 8'hD6, 8'hE7, 8'h1F
   };

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req   = '0;
   logic [4*NREQ-1:0] addr  = '0;
   logic [NREQ-1:0]   ack;
   logic [NREQ-1:0]   rvalid;
   logic [7:0]        rdata;
   logic              busy;
   logic [3:0]        rom_a;
   logic [7:0]        rom_o;

   assign rom_o = ROM_TBL[rom_a];

   rom_rd_arbiter #(
      .NREQ (NREQ)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .addr   (addr),
      .ack    (ack),
      .rvalid (rvalid),
      .rdata  (rdata),
      .busy   (busy),
      .rom_a  (rom_a),
      .rom_o  (rom_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         id;
      int         cyc;
      logic [7:0] data;
      logic [3:0] a;
   } exp_t;

   exp_t ack_q[$];
   exp_t rv_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (ack !== '0) begin
         if (ack_q.size() == 0) begin
            chk("ack_unexpected", 32'(ack), 32'(0));
         end else begin
            e = ack_q.pop_front();
            chk("ack_vec", 32'(ack), 32'(1) << e.id);
            chk("ack_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
      if (rvalid !== '0) begin
         if (rv_q.size() == 0) begin
            chk("rvalid_unexpected", 32'(rvalid), 32'(0));
         end else begin
            e = rv_q.pop_front();
            chk("rvalid_vec", 32'(rvalid), 32'(1) << e.id);
            chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
            chk("rdata", 32'(rdata), 32'(e.data));
            chk("rom_a", 32'(rom_a), 32'(e.a));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int id, input logic [3:0] a);
      addr[id*4 +: 4] = a;
   endtask

   task automatic push_txn(input int id, input int c, input logic [3:0] a, input bit with_rv);
      ack_q.push_back('{id, c, 8'h00, a});
      if (with_rv) rv_q.push_back('{id, c + LAT, ROM_TBL[a], a});
   endtask

   // Caller is at the start of an IDLE cycle; returns at the start of the next IDLE cycle.
   task automatic single(input int id, input logic [3:0] a);
      set_addr(id, a);
      req[id] = 1'b1;
      push_txn(id, cyc, a, 1'b1);
      tick();
      req[id] = 1'b0;
      repeat (LAT) tick();
   endtask

   initial begin : stim
      int c;

      tick();
      chk("rst_ack", 32'(ack), 32'(0));
      chk("rst_rvalid", 32'(rvalid), 32'(0));
      chk("rst_rdata", 32'(rdata), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_rom_a", 32'(rom_a), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      single(2, 4'h0);
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_rdata_hold", 32'(rdata), 32'h1B);

      single(0, 4'h4);
      single(0, 4'h8);
      single(0, 4'hF);
      chk("idle_rdata_hold2", 32'(rdata), 32'h1F);
      chk("idle_rom_a_hold", 32'(rom_a), 32'hF);

      // Lone requester held across three grants.
      set_addr(3, 4'h9);
      req[3] = 1'b1;
      c = cyc;
      for (int k = 0; k < 3; k++) push_txn(3, c + k*SP, 4'h9, 1'b1);
      for (int t = 0; t <= 2*SP + LAT; t++) begin
         chk("busy_seq", 32'(busy), 32'((t % SP) != 0));
         tick();
         if (t + 1 == 2*SP + 1) req[3] = 1'b0;
      end

      // All requesters held: last grant was 3, so rotation restarts at 0.
      for (int i = 0; i < NREQ; i++) set_addr(i, 4'hF);
      req = '1;
      c = cyc;
      push_txn(0, c,        4'hF, 1'b1);
      push_txn(1, c + SP,   4'hF, 1'b1);
      push_txn(2, c + 2*SP, 4'hF, 1'b1);
      push_txn(3, c + 3*SP, 4'hF, 1'b1);
      push_txn(0, c + 4*SP, 4'hF, 1'b1);
      repeat (4*SP) tick();
      tick();
      req = '0;
      repeat (LAT) tick();

      // Reset while requester 1's read is in READ: no rvalid may follow.
      set_addr(1, 4'h5);
      req = 4'b0010;
      push_txn(1, cyc, 4'h5, 1'b0);
      tick();
      req = '0;
      repeat (LAT - 2) tick();
      chk("pre_rst_busy", 32'(busy), 32'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(ack), 32'(0));
      chk("mid_rst_rvalid", 32'(rvalid), 32'(0));
      chk("mid_rst_rdata", 32'(rdata), 32'(0));
      chk("mid_rst_busy", 32'(busy), 32'(0));
      chk("mid_rst_rom_a", 32'(rom_a), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();

      set_addr(0, 4'h8);
      set_addr(1, 4'h4);
      req = 4'b0011;
      push_txn(0, cyc, 4'h8, 1'b1);
      tick();
      req = '0;
      repeat (LAT) tick();

      repeat (3) tick();
      chk("ack_q_drained", 32'(ack_q.size()), 32'(0));
      chk("rv_q_drained", 32'(rv_q.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
